// File: rtl/simd_regfile_pkg.sv
// simd_regfile_pkg: shared types and address helpers for the SIMD FP register file.
//   simd_rf_state_e : sequencer state (eInit = zeroing sweep, eReady = normal operation)
//   row_of/lane_of  : split a flat entry address into row and lane fields
//   safe_clog2      : clog2 that never returns 0, for index widths
package simd_regfile_pkg;

  typedef enum logic [0:0] {eInit, eReady} simd_rf_state_e;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Row field is everything above the lane bits.
  function automatic int unsigned row_of(input int unsigned addr, input int unsigned lane_bits);
    return addr >> lane_bits;
  endfunction

  function automatic int unsigned lane_of(input int unsigned addr, input int unsigned lane_bits);
    return addr & ((32'd1 << lane_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/simd_regfile_bank.sv
// simd_regfile_bank: one lane of the register file, rows_p x width_p, no reset on storage.
//   clk_i        clock
//   sweep_i      zeroing sweep active; overrides the user write
//   sweep_row_i  row being cleared this cycle
//   w_v_i        user write enable for this lane
//   w_row_i      user write row
//   w_data_i     user write data
//   r_row_i      taps_p read rows (combinational taps)
//   r_data_o     taps_p read data, storage contents as of the current cycle
module simd_regfile_bank #(
  parameter int width_p = 132,
  parameter int rows_p  = 8,
  parameter int taps_p  = 4,
  localparam int row_w_lp = simd_regfile_pkg::safe_clog2(rows_p)
) (
  input  logic                            clk_i,
  input  logic                            sweep_i,
  input  logic [row_w_lp-1:0]             sweep_row_i,
  input  logic                            w_v_i,
  input  logic [row_w_lp-1:0]             w_row_i,
  input  logic [width_p-1:0]              w_data_i,
  input  logic [taps_p-1:0][row_w_lp-1:0] r_row_i,
  output logic [taps_p-1:0][width_p-1:0]  r_data_o
);

  logic [width_p-1:0] mem [rows_p];

  logic                we;
  logic [row_w_lp-1:0] wrow;
  logic [width_p-1:0]  wdata;

  // Single write port: the sweep wins, so user writes during INIT are lost.
  assign we    = sweep_i | w_v_i;
  assign wrow  = sweep_i ? sweep_row_i : w_row_i;
  assign wdata = sweep_i ? '0 : w_data_i;

  always_ff @(posedge clk_i) begin
    if (we) mem[wrow] <= wdata;
  end

  for (genvar t = 0; t < taps_p; t++) begin : g_tap
    assign r_data_o[t] = mem[r_row_i[t]];
  end

endmodule

// File: rtl/simd_regfile_gen.sv
// simd_regfile_gen: SIMD FP register file, rows of lanes_p entries, r_ports_p
// registered read ports, per-lane writes, full-row group read on grp_port_p,
// and a zeroing sequencer that clears the file after reset or on clear_i.
//   clk_i / reset_n_i  clock, async active-low reset
//   clear_i            pulse in READY to re-zero the file
//   ready_o            sweep done, writes accepted
//   w_v_i/w_addr_i/w_data_i   per-lane write (row field of w_addr_i only)
//   r_v_i/r_addr_i     per-port read enable and address
//   r_data_o           registered per-port read data (holds when not enabled)
//   grp_data_o         registered full row at r_addr_i[grp_port_p]
// Build option: SIMD_REGFILE_BYPASS_EN forwards same-cycle write data to reads in READY.
module simd_regfile_gen
  import simd_regfile_pkg::*;
#(
  parameter int width_p    = 132,
  parameter int els_p      = 32,
  parameter int lanes_p    = 4,
  parameter int r_ports_p  = 3,
  parameter int grp_port_p = 1,
  localparam int addr_width_lp = safe_clog2(els_p),
  localparam int lane_bits_lp  = $clog2(lanes_p),
  localparam int rows_lp       = els_p / lanes_p,
  localparam int row_w_lp      = safe_clog2(rows_lp)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   clear_i,
  output logic                                   ready_o,
  input  logic [lanes_p-1:0]                     w_v_i,
  input  logic [addr_width_lp-1:0]               w_addr_i,
  input  logic [lanes_p-1:0][width_p-1:0]        w_data_i,
  input  logic [r_ports_p-1:0]                   r_v_i,
  input  logic [r_ports_p-1:0][addr_width_lp-1:0] r_addr_i,
  output logic [r_ports_p-1:0][width_p-1:0]      r_data_o,
  output logic [lanes_p-1:0][width_p-1:0]        grp_data_o
);

  localparam int taps_lp = r_ports_p + 1;

  simd_rf_state_e      state_r, state_n;
  logic [row_w_lp-1:0] row_cnt_r, row_cnt_n;
  logic                sweep;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= eInit;
      row_cnt_r <= '0;
    end else begin
      state_r   <= state_n;
      row_cnt_r <= row_cnt_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    row_cnt_n = row_cnt_r;
    case (state_r)
      eInit: begin
        // clear_i is deliberately ignored here: the sweep is never restarted.
        row_cnt_n = row_cnt_r + 1'b1;
        if (row_cnt_r == row_w_lp'(rows_lp - 1)) begin
          state_n   = eReady;
          row_cnt_n = '0;
        end
      end
      eReady: begin
        if (clear_i) begin
          state_n   = eInit;
          row_cnt_n = '0;
        end
      end
      default: state_n = eInit;
    endcase
  end

  assign sweep   = (state_r == eInit);
  assign ready_o = (state_r == eReady);

  // ---------------- address decode ----------------
  logic [row_w_lp-1:0]                   w_row;
  logic [r_ports_p-1:0][row_w_lp-1:0]    r_row;
  logic [r_ports_p-1:0][lane_bits_lp-1:0] r_lane;
  logic [taps_lp-1:0][row_w_lp-1:0]      tap_row;

  assign w_row = row_w_lp'(row_of(32'(w_addr_i), lane_bits_lp));

  for (genvar p = 0; p < r_ports_p; p++) begin : g_dec
    assign r_row[p]   = row_w_lp'(row_of(32'(r_addr_i[p]), lane_bits_lp));
    assign r_lane[p]  = lane_bits_lp'(lane_of(32'(r_addr_i[p]), lane_bits_lp));
    assign tap_row[p] = r_row[p];
  end
  // Extra tap on every lane feeds the group read.
  assign tap_row[r_ports_p] = r_row[grp_port_p];

  // ---------------- per-lane banks ----------------
  logic [lanes_p-1:0][taps_lp-1:0][width_p-1:0] bank_rd;

  for (genvar i = 0; i < lanes_p; i++) begin : g_bank
    simd_regfile_bank #(
      .width_p (width_p),
      .rows_p  (rows_lp),
      .taps_p  (taps_lp)
    ) u_bank (
      .clk_i       (clk_i),
      .sweep_i     (sweep),
      .sweep_row_i (row_cnt_r),
      .w_v_i       (w_v_i[i]),
      .w_row_i     (w_row),
      .w_data_i    (w_data_i[i]),
      .r_row_i     (tap_row),
      .r_data_o    (bank_rd[i])
    );
  end

  // ---------------- read muxes ----------------
  logic [r_ports_p-1:0][width_p-1:0] rd_n;
  logic [lanes_p-1:0][width_p-1:0]   grp_n;

  always_comb begin
    for (int p = 0; p < r_ports_p; p++) begin
      rd_n[p] = bank_rd[r_lane[p]][p];
`ifdef SIMD_REGFILE_BYPASS_EN
      if (ready_o && w_v_i[r_lane[p]] && (w_row == r_row[p]))
        rd_n[p] = w_data_i[r_lane[p]];
`endif
    end
    for (int i = 0; i < lanes_p; i++) begin
      grp_n[i] = bank_rd[i][r_ports_p];
`ifdef SIMD_REGFILE_BYPASS_EN
      if (ready_o && w_v_i[i] && (w_row == r_row[grp_port_p]))
        grp_n[i] = w_data_i[i];
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data_o   <= '0;
      grp_data_o <= '0;
    end else begin
      for (int p = 0; p < r_ports_p; p++)
        if (r_v_i[p]) r_data_o[p] <= rd_n[p];
      if (r_v_i[grp_port_p]) grp_data_o <= grp_n;
    end
  end

endmodule

// File: tb/tb_simd_regfile_gen.sv
// tb_simd_regfile_gen: directed bench for simd_regfile_gen, default build
// (lanes 4, els 32) plus a lanes 8 / els 64 instance for the basic checks.
module tb_simd_regfile_gen;

  localparam int W = 132;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic                clear;
  logic                ready;
  logic [3:0]          w_v;
  logic [4:0]          w_addr;
  logic [3:0][W-1:0]   w_data;
  logic [2:0]          r_v;
  logic [2:0][4:0]     r_addr;
  logic [2:0][W-1:0]   r_data;
  logic [3:0][W-1:0]   grp_data;

  // lanes 8 instance
  logic                clear8;
  logic                ready8;
  logic [7:0]          w_v8;
  logic [5:0]          w_addr8;
  logic [7:0][W-1:0]   w_data8;
  logic [2:0]          r_v8;
  logic [2:0][5:0]     r_addr8;
  logic [2:0][W-1:0]   r_data8;
  logic [7:0][W-1:0]   grp_data8;

  simd_regfile_gen u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clear), .ready_o(ready),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(r_data), .grp_data_o(grp_data)
  );

  simd_regfile_gen #(.lanes_p(8), .els_p(64)) u_dut8 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clear8), .ready_o(ready8),
    .w_v_i(w_v8), .w_addr_i(w_addr8), .w_data_i(w_data8),
    .r_v_i(r_v8), .r_addr_i(r_addr8), .r_data_o(r_data8), .grp_data_o(grp_data8)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [1055:0] got, input logic [1055:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got[527:0], exp[527:0]);
    end
  endtask

  function automatic logic [W-1:0] dv(input int k);
    return {4'(k), 32'hC0DE_0000 + 32'(k), 96'h0123_4567_89AB_CDEF_0011_2233 ^ {3{32'(k * 3 + 1)}}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready rises; bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic rd3(input int a0, input int a1, input int a2);
    r_v = 3'b111;
    r_addr[0] = 5'(a0); r_addr[1] = 5'(a1); r_addr[2] = 5'(a2);
    step();
    r_v = 3'b000;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int a = 0; a < 32; a += 3) begin
      rd3(a, (a + 1) % 32, (a + 2) % 32);
      for (int p = 0; p < 3; p++) chk(tag, r_data[p], '0);
    end
  endtask

  int n;
  logic [W-1:0] old_v, a_v, b_v;
  logic [3:0][W-1:0] grp_hold;

  initial begin
    clear = 0; w_v = '0; w_addr = '0; w_data = '0; r_v = '0; r_addr = '0;
    clear8 = 0; w_v8 = '0; w_addr8 = '0; w_data8 = '0; r_v8 = '0; r_addr8 = '0;

    // ---- reset state ----
    step(); step();
    chk("rst_ready", ready, 1'b0);
    chk("rst_rdata", r_data, '0);
    chk("rst_grp", grp_data, '0);
    chk("rst_grp8", grp_data8, '0);

    // ---- 1: sweep length, file reads zero ----
    rst_n = 1'b1;
    wait_ready(n);
    chk("sweep_len", n, 8);
    chk("sweep_len8", ready8, 1'b1);
    chk_all_zero("init_zero");

    // ---- 2: partial-lane write ----
    w_v = 4'b0101; w_addr = 5'd12;
    for (int i = 0; i < 4; i++) w_data[i] = dv(i);
    step();
    w_v = '0;
    r_v = 3'b111; r_addr[0] = 5'd12; r_addr[1] = 5'd13; r_addr[2] = 5'd14;
    step();
    r_v = '0;
    chk("wr_lane0", r_data[0], dv(0));
    chk("wr_lane1", r_data[1], '0);
    chk("wr_lane2", r_data[2], dv(2));
    chk("grp_row3", grp_data, {W'(0), dv(2), W'(0), dv(0)});

    // same on lanes 8: addr 12 is row 1
    w_v8 = 8'b0000_0101; w_addr8 = 6'd12;
    for (int i = 0; i < 8; i++) w_data8[i] = dv(40 + i);
    step();
    w_v8 = '0;
    r_v8 = 3'b111; r_addr8[0] = 6'd8; r_addr8[1] = 6'd9; r_addr8[2] = 6'd10;
    step();
    r_v8 = '0;
    chk("l8_lane0", r_data8[0], dv(40));
    chk("l8_lane1", r_data8[1], '0);
    chk("l8_lane2", r_data8[2], dv(42));
    chk("l8_grp", grp_data8, {W'(0), W'(0), W'(0), W'(0), W'(0), dv(42), W'(0), dv(40)});
    r_v8 = 3'b111; r_addr8[0] = 6'd0; r_addr8[1] = 6'd63; r_addr8[2] = 6'd33;
    step();
    r_v8 = '0;
    for (int p = 0; p < 3; p++) chk("l8_zero", r_data8[p], '0);

    // ---- 3: same-cycle write/read ----
    old_v = dv(77); a_v = dv(88); b_v = dv(99);
    w_v = 4'b0010; w_addr = 5'd5; w_data = '0; w_data[1] = old_v;
    step();
    w_data[1] = a_v;
    r_v = 3'b011; r_addr[0] = 5'd5; r_addr[1] = 5'd5;
    step();
    w_v = '0;
`ifdef SIMD_REGFILE_BYPASS_EN
    chk("rw_same", r_data[0], a_v);
    chk("rw_grp", grp_data, {W'(0), W'(0), a_v, W'(0)});
`else
    chk("rw_same", r_data[0], old_v);
    chk("rw_grp", grp_data, {W'(0), W'(0), old_v, W'(0)});
`endif
    step();
    r_v = '0;
    chk("rw_after", r_data[0], a_v);
    chk("rw_after_p1", r_data[1], a_v);
    grp_hold = grp_data;
    chk("rw_after_grp", grp_hold, {W'(0), W'(0), a_v, W'(0)});

    // ---- 6: outputs hold while r_v=0 and the address is rewritten ----
    w_v = 4'b0010; w_addr = 5'd5; w_data[1] = b_v;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_rd", r_data[0], a_v);
      chk("hold_grp", grp_data, grp_hold);
    end
    w_v = '0;
    r_v = 3'b001; r_addr[0] = 5'd5;
    step();
    r_v = '0;
    chk("hold_new", r_data[0], b_v);

    // ---- 4: fill, clear, writes dropped during sweep ----
    for (int r = 0; r < 8; r++) begin
      w_v = 4'b1111; w_addr = 5'(r * 4);
      for (int i = 0; i < 4; i++) w_data[i] = dv(r * 4 + i);
      step();
    end
    w_v = '0;
    rd3(9, 30, 0);
    chk("fill_9", r_data[0], dv(9));
    chk("fill_30", r_data[1], dv(30));
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_ready0", ready, 1'b0);
    w_v = 4'b1111;
    for (int i = 0; i < 4; i++) w_data[i] = dv(200 + i);
    n = 0;
    while (!ready && n < 30) begin
      w_addr = 5'((n % 8) * 4);
      clear = (n == 3);
      step();
      n++;
    end
    clear = 1'b0; w_v = '0;
    chk("clr_len", n, 8);
    chk_all_zero("clr_zero");

    // ---- 5: reset mid-sweep restarts the sweep ----
    @(posedge clk); #2;
    rst_n = 1'b0;
    #2;
    chk("rst2_rdata", r_data, '0);
    chk("rst2_ready", ready, 1'b0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("mid_ready", ready, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_ready(n);
    chk("restart_len", n, 8);
    rd3(1, 17, 31);
    for (int p = 0; p < 3; p++) chk("restart_zero", r_data[p], '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
